// File: rtl/fetcher_pkg.sv
// Shared constants and types for the instruction fetch stage: opcodes,
// FSM state encoding, the queued entry layout and immediate decoders.
package fetcher_pkg;

    localparam int BP_TAG_WIDTH = 8;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        FETCH_IDLE    = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_STALL   = 2'd2,
        FETCH_DISCARD = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        jump;
    } fetch_entry_t;

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetcher_predecode.sv
// Combinational predecode of a fetched word: classifies JAL / conditional
// branch and computes the next fetch PC given the predictor's answer.
module fetcher_predecode
    import fetcher_pkg::*;
(
    input  logic [31:0] inst_i,
    input  logic [31:0] pc_i,
    input  logic        jump_i,
    output logic [31:0] next_pc_o,
    output logic        is_branch_o,
    output logic        is_jal_o
);

    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        next_pc_o   = pc_i + 32'd4;
        is_branch_o = 1'b0;
        is_jal_o    = 1'b0;
        case (inst_i[6:0])
            OPC_JAL: begin
                is_jal_o  = 1'b1;
                next_pc_o = pc_i + j_imm(inst_i);
            end
            OPC_BRANCH: begin
                is_branch_o = 1'b1;
                if (jump_i) begin
                    next_pc_o = pc_i + b_imm(inst_i);
                end
            end
            // Indirect target depends on rs1, which fetch cannot see.
            OPC_JALR: ;
            default:  ;
        endcase
    end

endmodule

// File: rtl/fetcher.sv
// Instruction fetch stage: owns the PC, keeps one icache request in flight,
// consults the branch predictor on branches and pushes into the IQ.
module fetcher
    import fetcher_pkg::*;
#(
    parameter int          BP_TAG_BITS = BP_TAG_WIDTH,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,

    output logic                   out_icache_ce,
    output logic [31:0]            out_icache_addr,
    input  logic                   in_icache_ce,
    input  logic [31:0]            in_icache_inst,

    output logic [BP_TAG_BITS-1:0] out_bp_tag,
    input  logic                   in_bp_jump_ce,

    input  logic                   in_iq_full,
    output logic                   out_iq_ce,
    output logic [31:0]            out_iq_inst,
    output logic [31:0]            out_iq_pc,
    output logic                   out_iq_jump_ce,

    input  logic                   in_rob_flush_ce,
    input  logic [31:0]            in_rob_target_pc
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic         icache_ce_q;
    logic         iq_ce_q;
    fetch_entry_t iq_q;
    fetch_entry_t hold_q;
    logic [31:0]  hold_next_q;

    logic [31:0]  next_pc_d;
    logic         is_branch_d;
    logic         is_jal_d;
    logic         jump_d;
    fetch_entry_t resp_d;

    fetcher_predecode u_predecode (
        .inst_i      (in_icache_inst),
        .pc_i        (pc_q),
        .jump_i      (in_bp_jump_ce),
        .next_pc_o   (next_pc_d),
        .is_branch_o (is_branch_d),
        .is_jal_o    (is_jal_d)
    );

    assign jump_d = is_jal_d | (is_branch_d & in_bp_jump_ce);
    assign resp_d = '{inst: in_icache_inst, pc: pc_q, jump: jump_d};

    assign out_icache_ce   = icache_ce_q;
    assign out_icache_addr = pc_q;
    assign out_bp_tag      = pc_q[BP_TAG_BITS+1:2];
    // NOTE: the push strobe is held across rdy=0 and only masked here, so a
    // push that lands on a frozen cycle is presented once rdy returns.
    assign out_iq_ce       = iq_ce_q & rdy;
    assign out_iq_inst     = iq_q.inst;
    assign out_iq_pc       = iq_q.pc;
    assign out_iq_jump_ce  = iq_q.jump;

    // NOTE: all state updates use non-blocking assignments so every branch
    // below reads the pre-edge values of pc_q, hold_q and state_q.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= FETCH_IDLE;
            pc_q        <= RESET_PC;
            icache_ce_q <= 1'b0;
            iq_ce_q     <= 1'b0;
            iq_q        <= '0;
            hold_q      <= '0;
            hold_next_q <= '0;
        end else if (rdy) begin
            iq_ce_q <= 1'b0;
            if (in_rob_flush_ce) begin
                pc_q        <= in_rob_target_pc;
                hold_q      <= '0;
                hold_next_q <= '0;
                // A request still in flight must be drained before refetching.
                if ((state_q == FETCH_WAIT || state_q == FETCH_DISCARD) && !in_icache_ce) begin
                    state_q <= FETCH_DISCARD;
                end else begin
                    state_q     <= FETCH_IDLE;
                    icache_ce_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    FETCH_IDLE: begin
                        if (!in_iq_full) begin
                            icache_ce_q <= 1'b1;
                            state_q     <= FETCH_WAIT;
                        end
                    end
                    FETCH_WAIT: begin
                        if (in_icache_ce) begin
                            icache_ce_q <= 1'b0;
                            if (!in_iq_full) begin
                                iq_ce_q <= 1'b1;
                                iq_q    <= resp_d;
                                pc_q    <= next_pc_d;
                                state_q <= FETCH_IDLE;
                            end else begin
                                hold_q      <= resp_d;
                                hold_next_q <= next_pc_d;
                                state_q     <= FETCH_STALL;
                            end
                        end
                    end
                    FETCH_STALL: begin
                        if (!in_iq_full) begin
                            iq_ce_q <= 1'b1;
                            iq_q    <= hold_q;
                            pc_q    <= hold_next_q;
                            state_q <= FETCH_IDLE;
                        end
                    end
                    FETCH_DISCARD: begin
                        if (in_icache_ce) begin
                            icache_ce_q <= 1'b0;
                            state_q     <= FETCH_IDLE;
                        end
                    end
                    default: begin
                        state_q     <= FETCH_IDLE;
                        icache_ce_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetcher.sv
// Self-checking bench for fetcher: directed scenarios followed by random
// icache latency, backpressure, stalls and redirects against a reference model.
module tb_fetcher;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_icache_ce;
    logic [31:0] in_icache_inst;
    logic        in_bp_jump_ce;
    logic        in_iq_full;
    logic        in_rob_flush_ce;
    logic [31:0] in_rob_target_pc;
    logic        out_icache_ce;
    logic [31:0] out_icache_addr;
    logic [7:0]  out_bp_tag;
    logic        out_iq_ce;
    logic [31:0] out_iq_inst;
    logic [31:0] out_iq_pc;
    logic        out_iq_jump_ce;

    always #5 clk = ~clk;

    fetcher #(.BP_TAG_BITS(8), .RESET_PC(32'h0)) dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .out_icache_ce    (out_icache_ce),
        .out_icache_addr  (out_icache_addr),
        .in_icache_ce     (in_icache_ce),
        .in_icache_inst   (in_icache_inst),
        .out_bp_tag       (out_bp_tag),
        .in_bp_jump_ce    (in_bp_jump_ce),
        .in_iq_full       (in_iq_full),
        .out_iq_ce        (out_iq_ce),
        .out_iq_inst      (out_iq_inst),
        .out_iq_pc        (out_iq_pc),
        .out_iq_jump_ce   (out_iq_jump_ce),
        .in_rob_flush_ce  (in_rob_flush_ce),
        .in_rob_target_pc (in_rob_target_pc)
    );

    localparam logic [31:0] ADDI = 32'h0010_0093;
    localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
    localparam logic [31:0] JAL_800 = 32'h0010_006F;

    int total = 0;
    int bad = 0;

    // Reference model state
    logic [31:0] m_pc;
    bit          outstanding;
    bit          stale;
    logic [31:0] req_addr;
    int          lat;
    bit          have_entry;
    bit          due;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_jump;
    int          pushes;
    logic [31:0] last_inst;
    logic [31:0] last_pc;
    logic        last_jump;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Next PC and prediction from the instruction-set rules, in plain integers.
    function automatic void predict(input logic [31:0] inst, input logic [31:0] pc,
                                    input logic bp, output logic [31:0] nxt, output logic jmp);
        int off;
        jmp = 1'b0;
        nxt = pc + 32'd4;
        if (inst[6:0] == 7'b1101111) begin
            off = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096
                + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
            jmp = 1'b1;
            nxt = pc + 32'(off);
        end else if (inst[6:0] == 7'b1100011 && bp) begin
            off = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
            jmp = 1'b1;
            nxt = pc + 32'(off);
        end
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w[6:0] = 7'b1101111;
            1: w[6:0] = 7'b1100011;
            2: w[6:0] = 7'b1100111;
            default: ;
        endcase
        return w;
    endfunction

    task automatic model_step(input logic r, input logic f, input logic fl, input logic [31:0] tgt,
                              input logic resp, input logic [31:0] inst, input logic bp);
        logic [31:0] nxt;
        logic        jmp;
        if (!r) return;
        if (have_entry && due) have_entry = 0;
        if (fl) begin
            m_pc = tgt;
            have_entry = 0;
            if (outstanding) begin
                if (resp) outstanding = 0;
                else stale = 1;
            end
        end else begin
            if (have_entry && !due && !f) due = 1;
            if (resp && outstanding) begin
                outstanding = 0;
                if (!stale) begin
                    predict(inst, m_pc, bp, nxt, jmp);
                    have_entry = 1;
                    due = !f;
                    e_inst = inst;
                    e_pc = m_pc;
                    e_jump = jmp;
                    m_pc = nxt;
                end
                stale = 0;
            end
        end
    endtask

    task automatic observe_req();
        if (outstanding) begin
            check("icache_ce_held", 32'(out_icache_ce), 32'd1);
            if (!stale) begin
                check("icache_addr_stable", out_icache_addr, req_addr);
                check("bp_tag", 32'(out_bp_tag), 32'(req_addr[9:2]));
            end
        end else if (out_icache_ce) begin
            check("req_addr", out_icache_addr, m_pc);
            check("req_while_entry", 32'(have_entry), 32'd0);
            outstanding = 1;
            stale = 0;
            req_addr = m_pc;
            lat = $urandom_range(0, 3);
        end
    endtask

    task automatic tick(input logic r, input logic f, input logic fl, input logic [31:0] tgt,
                        input logic resp, input logic [31:0] inst, input logic bp);
        logic exp_push;
        rdy = r;
        in_iq_full = f;
        in_rob_flush_ce = fl;
        in_rob_target_pc = tgt;
        in_icache_ce = resp;
        in_icache_inst = inst;
        in_bp_jump_ce = bp;
        #1;
        exp_push = have_entry && due && r;
        check("iq_ce", 32'(out_iq_ce), 32'(exp_push));
        if (exp_push && out_iq_ce) begin
            check("iq_inst", out_iq_inst, e_inst);
            check("iq_pc", out_iq_pc, e_pc);
            check("iq_jump", 32'(out_iq_jump_ce), 32'(e_jump));
            last_inst = out_iq_inst;
            last_pc = out_iq_pc;
            last_jump = out_iq_jump_ce;
            pushes++;
        end
        model_step(r, f, fl, tgt, resp, inst, bp);
        @(negedge clk);
        observe_req();
    endtask

    task automatic idle_until_req();
        int n = 0;
        while (!outstanding && n < 20) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'($urandom));
            n++;
        end
        check("req_timeout", 32'(outstanding), 32'd1);
    endtask

    task automatic redirect(input logic [31:0] tgt);
        tick(1'b1, 1'b0, 1'b1, tgt, 1'b0, 32'h0, 1'b0);
        if (outstanding) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, $urandom, 1'b0);
    endtask

    initial begin
        int p;
        logic r, f, fl, resp;
        rst = 1'b1;
        rdy = 1'b1;
        in_icache_ce = 1'b0;
        in_icache_inst = 32'h0;
        in_bp_jump_ce = 1'b0;
        in_iq_full = 1'b0;
        in_rob_flush_ce = 1'b0;
        in_rob_target_pc = 32'h0;
        m_pc = 32'h0;
        outstanding = 0;
        stale = 0;
        have_entry = 0;
        due = 0;
        pushes = 0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_icache_ce", 32'(out_icache_ce), 32'd0);
        check("rst_icache_addr", out_icache_addr, 32'h0);
        check("rst_bp_tag", 32'(out_bp_tag), 32'd0);
        check("rst_iq_ce", 32'(out_iq_ce), 32'd0);
        check("rst_iq_inst", out_iq_inst, 32'h0);
        check("rst_iq_pc", out_iq_pc, 32'h0);
        check("rst_iq_jump", 32'(out_iq_jump_ce), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        observe_req();

        // Straight-line fetch from reset
        idle_until_req();
        check("dir_first_addr", req_addr, 32'h0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, ADDI, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_addi_inst", last_inst, ADDI);
        check("dir_addi_pc", last_pc, 32'h0);
        check("dir_addi_jump", 32'(last_jump), 32'd0);
        idle_until_req();
        check("dir_addi_next", req_addr, 32'h4);

        // Branch predicted taken, then not taken
        redirect(32'h100);
        idle_until_req();
        check("dir_beq_addr", req_addr, 32'h100);
        check("dir_beq_tag", 32'(out_bp_tag), 32'h40);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, BEQ_M8, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_beq_t_jump", 32'(last_jump), 32'd1);
        check("dir_beq_t_pc", last_pc, 32'h100);
        idle_until_req();
        check("dir_beq_t_next", req_addr, 32'hF8);
        redirect(32'h100);
        idle_until_req();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, BEQ_M8, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("dir_beq_nt_jump", 32'(last_jump), 32'd0);
        idle_until_req();
        check("dir_beq_nt_next", req_addr, 32'h104);

        // JAL ignores the predictor
        redirect(32'h20);
        idle_until_req();
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, JAL_800, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_jal_jump", 32'(last_jump), 32'd1);
        idle_until_req();
        check("dir_jal_next", req_addr, 32'h820);

        // Backpressure: full for three cycles starting at the response
        p = pushes;
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, ADDI, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_full_no_push", 32'(pushes), 32'(p));
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_full_one_push", 32'(pushes), 32'(p + 1));
        check("dir_full_pc", last_pc, 32'h820);
        idle_until_req();
        check("dir_full_next", req_addr, 32'h824);

        // Flush one cycle ahead of the response, then coincident with it
        p = pushes;
        tick(1'b1, 1'b0, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, ADDI, 1'b0);
        idle_until_req();
        check("dir_flush_wait_addr", req_addr, 32'h400);
        tick(1'b1, 1'b0, 1'b1, 32'h400, 1'b1, ADDI, 1'b0);
        idle_until_req();
        check("dir_flush_coinc_addr", req_addr, 32'h400);
        check("dir_flush_no_push", 32'(pushes), 32'(p));

        // rdy low for four cycles while waiting
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'($urandom));
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, ADDI, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        check("dir_rdy_pc", last_pc, 32'h400);
        idle_until_req();
        check("dir_rdy_next", req_addr, 32'h404);

        // Random traffic
        p = pushes;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 9) != 0);
            f = ($urandom_range(0, 3) == 0);
            resp = 1'b0;
            if (outstanding && r) begin
                if (lat == 0) resp = 1'b1;
                else lat--;
            end
            fl = r && ($urandom_range(0, 24) == 0) && !(resp && stale);
            tick(r, f, fl, $urandom & 32'hFFFF_FFFC, resp, gen_inst(), 1'($urandom));
        end
        check("rand_activity", 32'(pushes - p > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetcher.md
Name: fetcher

Overview:
- Instruction fetch stage that sits directly upstream of the 2-bit branch predictor.
- Owns the PC and issues one instruction request at a time to the icache.
- For each fetched conditional branch it queries the predictor with a PC-derived tag and uses the answer to pick the next PC.
- Pushes {inst, pc, predicted-jump} into the instruction queue; the ROB redirects it on mispredict/flush.

Parameters:
- BP_TAG_BITS, 8, predictor index width; tag = pc[BP_TAG_BITS+1:2]; must match `BP_TAG_WIDTH.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global enable; when 0, all state holds.
- out_icache_ce  out  1  request valid; held high until the response arrives.
- out_icache_addr  out  32  request address (= pc).
- in_icache_ce  in  1  response valid, one-cycle pulse.
- in_icache_inst  in  32  instruction word, valid with in_icache_ce.
- out_bp_tag  out  BP_TAG_BITS  predictor query, combinational from pc.
- in_bp_jump_ce  in  1  predictor answer: 1 = taken.
- in_iq_full  in  1  instruction queue cannot accept this cycle.
- out_iq_ce  out  1  push strobe, one cycle per instruction.
- out_iq_inst  out  32  instruction.
- out_iq_pc  out  32  instruction address.
- out_iq_jump_ce  out  1  predicted taken (always 1 for JAL).
- in_rob_flush_ce  in  1  redirect request.
- in_rob_target_pc  in  32  redirect PC.

Behaviour:
- Reset (async, rst=0):
  - pc=RESET_PC, state=IDLE.
  - out_icache_ce=0, out_iq_ce=0, out_iq_inst/pc=0, out_iq_jump_ce=0, held-instruction registers cleared.
- All transitions below happen only when rdy=1; with rdy=0 every register holds and out_iq_ce is forced 0.
- States:
  - IDLE:
    - If !in_iq_full: assert out_icache_ce with addr=pc, go to WAIT.
    - Otherwise stay in IDLE.
  - WAIT:
    - Hold out_icache_ce/addr.
    - On in_icache_ce, decode opcode inst[6:0]:
      - 1101111 (JAL): next = pc + J-imm, jump=1.
      - 1100011 (branch): jump = in_bp_jump_ce sampled that cycle; next = jump ? pc + B-imm : pc + 4.
      - Anything else, including JALR: next = pc + 4, jump=0.
    - If !in_iq_full: out_iq_ce=1 next cycle with {inst, pc, jump}, pc <= next, go to IDLE.
    - Else latch {inst, pc, jump, next} and go to STALL.
  - STALL:
    - Wait for !in_iq_full, then push the latched entry, pc <= next, go to IDLE.
  - DISCARD:
    - Keep out_icache_ce high until in_icache_ce arrives.
    - Drop the returned word (no push, pc unchanged), then go to IDLE.
- Immediates and arithmetic:
  - B-imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}).
  - J-imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - All PC arithmetic is 32-bit modulo 2^32; wrap is silent.
- Latency: request issued the cycle after entering IDLE; push is registered, one cycle after the response (or after iq frees).
- out_bp_tag = pc[BP_TAG_BITS+1:2] at all times; the predictor is only consulted on the response cycle.
- Flush has priority over everything:
  - in_rob_flush_ce=1 sets pc <= in_rob_target_pc and suppresses any push that cycle.
  - Any latched STALL entry is discarded.
  - From WAIT without a same-cycle response, go to DISCARD. If the response arrives in the same cycle as the flush, drop it and go to IDLE.
  - Flush while in DISCARD: update pc, stay in DISCARD.
  - Flush in IDLE or STALL: go to IDLE.
- Only one outstanding icache request at any time.
- Async reset mid-WAIT abandons the request; the icache must tolerate the request dropping.

Decomposition:
- Add to the shared constants header: opcodes OPC_JAL, OPC_BRANCH, OPC_JALR; state encodings FETCH_IDLE/WAIT/STALL/DISCARD (2-bit).
- Reuse the existing `BP_TAG_WIDTH.
- One natural combinational sub-module, fetch_predecode: inst and pc in, next_pc and is_branch out, jump taken as an input.

Test Plan:
- Reset: RESET_PC=0, icache returns ADDI, 2-cycle latency, iq empty -> first request addr 0; push {inst, pc=0, jump=0}; next request addr 4.
- Branch predicted taken: BEQ at pc=0x100 with imm=-8, in_bp_jump_ce=1 -> out_bp_tag=0x40, push jump=1, next request addr 0xF8. Repeat with in_bp_jump_ce=0 -> next request addr 0x104.
- JAL: at pc=0x20 with imm=+0x800 -> push jump=1, next addr 0x820, regardless of in_bp_jump_ce.
- Backpressure: in_iq_full=1 when the response arrives, held 3 cycles -> no push, no new request; single push on the cycle after full drops, with the correct pc.
- Flush in WAIT: flush to 0x400 one cycle before the response -> response dropped, no push, next request addr 0x400. Flush coincident with the response -> same result.
- rdy=0 for 4 cycles during WAIT while the response pulse is held off -> pc and outputs frozen; normal completion after rdy returns.
